renamer_recovery_sequencer: RTL and testbench

Control FSM that sequences the register renamer's maintenance operations. Runs post-reset (and on-demand) clearing of the speculative rd-to-phys table and free lists: 64 cycles, indices 0..63. On a writeback-suppress flush, drains the in-use list one entry per cycle so each entry's previous mapping is restored, and stalls rename while doing so. Sits between global control (gc) and the renamer, and is the only driver of init_clear, clear_index and the in-use-list restore pops.

---
 rtl/renamer_recovery_sequencer.sv | 157 +++++++++++++++
 tb/tb_renamer_recovery_sequencer.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/renamer_recovery_sequencer.sv
// Sequences renamer maintenance: post-reset/on-demand table clear and flush-time in-use list drain.
// Optional build macro RENAMER_RECOVERY_WATCHDOG_EN adds a drain watchdog (watchdog_err output).
module renamer_recovery_sequencer #(
  parameter int unsigned NUM_PHYS_REGS = 64,
  parameter int unsigned MAX_INFLIGHT  = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             init_req,
  input  logic                             flush_req,
  input  logic                             inuse_empty,
  output logic                             init_clear,
  output logic [$clog2(NUM_PHYS_REGS)-1:0] clear_index,
  output logic                             restore_valid,
  output logic                             rename_stall,
  output logic                             init_done,
  output logic [5:0]                       recover_cycles,
`ifdef RENAMER_RECOVERY_WATCHDOG_EN
  output logic                             watchdog_err,
`endif
  output logic                             busy
);

  localparam int unsigned IDX_W = $clog2(NUM_PHYS_REGS);
  localparam int unsigned RC_W  = 6;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHYS_REGS - 1);
  localparam logic [RC_W-1:0]  RC_MAX   = {RC_W{1'b1}};

  if (NUM_PHYS_REGS < 2 || MAX_INFLIGHT < 1) begin : g_bad_cfg
    $error("renamer_recovery_sequencer: unsupported parameter values");
  end

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_RECOVER = 2'd2,
    ST_SETTLE  = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  clear_index_q, clear_index_d;
  logic [RC_W-1:0]   recover_cycles_q, recover_cycles_d;
  logic              init_done_q, init_done_d;

`ifdef RENAMER_RECOVERY_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(MAX_INFLIGHT + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(MAX_INFLIGHT);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            wd_err_q, wd_err_d;
`endif

  // State and counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= ST_INIT;
      clear_index_q    <= '0;
      recover_cycles_q <= '0;
      init_done_q      <= 1'b0;
`ifdef RENAMER_RECOVERY_WATCHDOG_EN
      wd_cnt_q         <= '0;
      wd_err_q         <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      clear_index_q    <= clear_index_d;
      recover_cycles_q <= recover_cycles_d;
      init_done_q      <= init_done_d;
`ifdef RENAMER_RECOVERY_WATCHDOG_EN
      wd_cnt_q         <= wd_cnt_d;
      wd_err_q         <= wd_err_d;
`endif
    end
  end

  // Next-state logic; restore_valid is the only combinational output (follows inuse_empty)
  always_comb begin
    state_d          = state_q;
    clear_index_d    = clear_index_q;
    recover_cycles_d = recover_cycles_q;
    init_done_d      = 1'b0;
    restore_valid    = 1'b0;
`ifdef RENAMER_RECOVERY_WATCHDOG_EN
    wd_cnt_d         = wd_cnt_q;
    wd_err_d         = wd_err_q;
`endif
    case (state_q)
      ST_INIT: begin
        if (init_req) begin
          clear_index_d = '0;
        end else if (clear_index_q == LAST_IDX) begin
          clear_index_d = '0;
          state_d       = ST_IDLE;
          init_done_d   = 1'b1;
        end else begin
          clear_index_d = clear_index_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (init_req) begin
          state_d       = ST_INIT;
          clear_index_d = '0;
        end else if (flush_req && !inuse_empty) begin
          state_d          = ST_RECOVER;
          recover_cycles_d = '0;
`ifdef RENAMER_RECOVERY_WATCHDOG_EN
          wd_cnt_d         = '0;
`endif
        end
      end
      ST_RECOVER: begin
        if (init_req) begin
          state_d       = ST_INIT;
          clear_index_d = '0;
        end else if (inuse_empty) begin
          state_d = ST_SETTLE;
        end else begin
          restore_valid = 1'b1;
          if (recover_cycles_q != RC_MAX) begin
            recover_cycles_d = recover_cycles_q + 1'b1;
          end
`ifdef RENAMER_RECOVERY_WATCHDOG_EN
          // This pop exceeds the in-use list depth: the drain cannot be legal
          if (wd_cnt_q == WD_LIMIT) begin
            wd_err_d      = 1'b1;
            state_d       = ST_INIT;
            clear_index_d = '0;
          end else begin
            wd_cnt_d = wd_cnt_q + 1'b1;
          end
`endif
        end
      end
      ST_SETTLE: begin
        state_d = ST_IDLE;
        if (init_req) begin
          state_d       = ST_INIT;
          clear_index_d = '0;
        end
      end
      default: begin
        state_d       = ST_INIT;
        clear_index_d = '0;
      end
    endcase
  end

  assign init_clear     = (state_q == ST_INIT);
  assign rename_stall   = (state_q != ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign clear_index    = clear_index_q;
  assign recover_cycles = recover_cycles_q;
  assign init_done      = init_done_q;
`ifdef RENAMER_RECOVERY_WATCHDOG_EN
  assign watchdog_err   = wd_err_q;
`endif

endmodule

// File: tb/tb_renamer_recovery_sequencer.sv
// Directed bench for renamer_recovery_sequencer; expected values are hand-derived per scenario.
// Watchdog scenario is compiled when RENAMER_RECOVERY_WATCHDOG_EN is defined.
module tb_renamer_recovery_sequencer;
  localparam int unsigned NPR = 64;
  localparam int unsigned IW  = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          init_req = 1'b0;
  logic          flush_req = 1'b0;
  logic          inuse_empty = 1'b1;
  logic          init_clear;
  logic [IW-1:0] clear_index;
  logic          restore_valid;
  logic          rename_stall;
  logic          init_done;
  logic [5:0]    recover_cycles;
  logic          busy;
`ifdef RENAMER_RECOVERY_WATCHDOG_EN
  logic          watchdog_err;
`endif

  int pass_cnt  = 0;
  int total_cnt = 0;

  renamer_recovery_sequencer #(.NUM_PHYS_REGS(NPR), .MAX_INFLIGHT(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .init_req       (init_req),
    .flush_req      (flush_req),
    .inuse_empty    (inuse_empty),
    .init_clear     (init_clear),
    .clear_index    (clear_index),
    .restore_valid  (restore_valid),
    .rename_stall   (rename_stall),
    .init_done      (init_done),
    .recover_cycles (recover_cycles),
`ifdef RENAMER_RECOVERY_WATCHDOG_EN
    .watchdog_err   (watchdog_err),
`endif
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Inputs change 2ns after the rising edge; outputs are sampled 1ns later
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({init_clear, rename_stall, busy, restore_valid, init_done, clear_index, recover_cycles} !==
        {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0})
      $display("FAIL reset_values got clr=%0b stall=%0b busy=%0b rv=%0b done=%0b idx=%0d rc=%0d exp 1 1 1 0 0 0 0",
               init_clear, rename_stall, busy, restore_valid, init_done, clear_index, recover_cycles);
    else pass_cnt++;
`ifdef RENAMER_RECOVERY_WATCHDOG_EN
    total_cnt++;
    if (watchdog_err !== 1'b0) $display("FAIL reset_watchdog got=%0b exp=0", watchdog_err);
    else pass_cnt++;
`endif
    cyc();
    cyc();
    total_cnt++;
    if (clear_index !== 6'd0) $display("FAIL reset_hold_idx got=%0d exp=0", clear_index);
    else pass_cnt++;
  endtask

  task automatic run_clear(input string tag);
    for (int i = 0; i < 64; i++) begin
      #1;
      total_cnt++;
      if ({init_clear, rename_stall, busy, restore_valid, init_done, clear_index} !==
          {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, IW'(i)})
        $display("FAIL %s_clear_cycle%0d got clr=%0b stall=%0b rv=%0b done=%0b idx=%0d exp clr=1 stall=1 rv=0 done=0 idx=%0d",
                 tag, i, init_clear, rename_stall, restore_valid, init_done, clear_index, i);
      else pass_cnt++;
      cyc();
    end
    #1;
    total_cnt++;
    if ({init_clear, rename_stall, busy, init_done, clear_index} !== {4'b0001, 6'd0})
      $display("FAIL %s_done got clr=%0b stall=%0b busy=%0b done=%0b idx=%0d exp 0 0 0 1 0",
               tag, init_clear, rename_stall, busy, init_done, clear_index);
    else pass_cnt++;
  endtask

  task automatic test_init_sequence();
    rst = 1'b1;
    run_clear("boot");
    cyc();
    #1;
    total_cnt++;
    if ({init_done, rename_stall} !== 2'b00)
      $display("FAIL boot_done_pulse got done=%0b stall=%0b exp 0 0", init_done, rename_stall);
    else pass_cnt++;
  endtask

  task automatic test_flush_drain();
    cyc();
    inuse_empty = 1'b0;
    flush_req   = 1'b1;
    #1;
    total_cnt++;
    if ({restore_valid, busy} !== 2'b00)
      $display("FAIL drain_idle_rv got rv=%0b busy=%0b exp 0 0", restore_valid, busy);
    else pass_cnt++;
    cyc();
    flush_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++;
      if ({restore_valid, rename_stall, busy, recover_cycles} !== {3'b111, 6'(i)})
        $display("FAIL drain_pop%0d got rv=%0b stall=%0b rc=%0d exp rv=1 stall=1 rc=%0d",
                 i, restore_valid, rename_stall, recover_cycles, i);
      else pass_cnt++;
      cyc();
    end
    inuse_empty = 1'b1;
    #1;
    total_cnt++;
    if ({restore_valid, rename_stall, recover_cycles} !== {2'b01, 6'd3})
      $display("FAIL drain_empty got rv=%0b stall=%0b rc=%0d exp 0 1 3", restore_valid, rename_stall, recover_cycles);
    else pass_cnt++;
    cyc();
    #1;
    total_cnt++;
    if ({restore_valid, rename_stall, busy, init_clear} !== 4'b0110)
      $display("FAIL drain_settle got rv=%0b stall=%0b busy=%0b clr=%0b exp 0 1 1 0",
               restore_valid, rename_stall, busy, init_clear);
    else pass_cnt++;
    cyc();
    #1;
    total_cnt++;
    if ({rename_stall, busy, recover_cycles} !== {2'b00, 6'd3})
      $display("FAIL drain_back_idle got stall=%0b busy=%0b rc=%0d exp 0 0 3", rename_stall, busy, recover_cycles);
    else pass_cnt++;
  endtask

  task automatic test_flush_empty();
    cyc();
    inuse_empty = 1'b1;
    flush_req   = 1'b1;
    cyc();
    flush_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total_cnt++;
      if ({busy, rename_stall, restore_valid, recover_cycles} !== {3'b000, 6'd3})
        $display("FAIL flush_empty_c%0d got busy=%0b stall=%0b rv=%0b rc=%0d exp 0 0 0 3",
                 i, busy, rename_stall, restore_valid, recover_cycles);
      else pass_cnt++;
      cyc();
    end
  endtask

  task automatic test_back_to_back();
    cyc();
    inuse_empty = 1'b0;
    flush_req   = 1'b1;
    cyc();
    flush_req = 1'b0;
    #1;
    total_cnt++;
    if ({restore_valid, recover_cycles} !== {1'b1, 6'd0})
      $display("FAIL b2b_first_pop got rv=%0b rc=%0d exp 1 0", restore_valid, recover_cycles);
    else pass_cnt++;
    cyc();
    inuse_empty = 1'b1;
    cyc();
    cyc();
    #1;
    total_cnt++;
    if ({busy, recover_cycles} !== {1'b0, 6'd1})
      $display("FAIL b2b_first_end got busy=%0b rc=%0d exp 0 1", busy, recover_cycles);
    else pass_cnt++;
    inuse_empty = 1'b0;
    flush_req   = 1'b1;
    cyc();
    #1;
    total_cnt++;
    if ({restore_valid, recover_cycles} !== {1'b1, 6'd0})
      $display("FAIL b2b_second_pop got rv=%0b rc=%0d exp 1 0", restore_valid, recover_cycles);
    else pass_cnt++;
    cyc();
    flush_req   = 1'b0;
    inuse_empty = 1'b1;
    #1;
    total_cnt++;
    if ({restore_valid, rename_stall, recover_cycles} !== {2'b01, 6'd1})
      $display("FAIL b2b_second_empty got rv=%0b stall=%0b rc=%0d exp 0 1 1", restore_valid, rename_stall, recover_cycles);
    else pass_cnt++;
    cyc();
    cyc();
    #1;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL b2b_second_idle got busy=%0b exp 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_init_abort();
    cyc();
    inuse_empty = 1'b0;
    flush_req   = 1'b1;
    cyc();
    flush_req = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      total_cnt++;
      if (restore_valid !== 1'b1) $display("FAIL abort_pop%0d got rv=%0b exp 1", i, restore_valid);
      else pass_cnt++;
      cyc();
    end
    init_req = 1'b1;
    #1;
    total_cnt++;
    if ({restore_valid, busy} !== 2'b01)
      $display("FAIL abort_rv_cycle got rv=%0b busy=%0b exp 0 1", restore_valid, busy);
    else pass_cnt++;
    cyc();
    init_req = 1'b0;
    // A flush pulse mid-clear must be ignored
    for (int i = 0; i < 64; i++) begin
      flush_req = (i == 10);
      #1;
      total_cnt++;
      if ({init_clear, restore_valid, clear_index} !== {2'b10, IW'(i)})
        $display("FAIL abort_clear_cycle%0d got clr=%0b rv=%0b idx=%0d exp 1 0 %0d",
                 i, init_clear, restore_valid, clear_index, i);
      else pass_cnt++;
      cyc();
    end
    flush_req = 1'b0;
    #1;
    total_cnt++;
    if ({init_done, init_clear, recover_cycles} !== {2'b10, 6'd2})
      $display("FAIL abort_done got done=%0b clr=%0b rc=%0d exp 1 0 2", init_done, init_clear, recover_cycles);
    else pass_cnt++;
    inuse_empty = 1'b1;
  endtask

  task automatic test_init_conflict();
    cyc();
    inuse_empty = 1'b0;
    init_req    = 1'b1;
    flush_req   = 1'b1;
    #1;
    total_cnt++;
    if (restore_valid !== 1'b0) $display("FAIL conflict_rv got=%0b exp=0", restore_valid);
    else pass_cnt++;
    cyc();
    init_req  = 1'b0;
    flush_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      total_cnt++;
      if ({init_clear, restore_valid, clear_index} !== {2'b10, IW'(i)})
        $display("FAIL conflict_pre%0d got clr=%0b rv=%0b idx=%0d exp 1 0 %0d",
                 i, init_clear, restore_valid, clear_index, i);
      else pass_cnt++;
      cyc();
    end
    // Restart mid-clear from index 5
    init_req = 1'b1;
    cyc();
    init_req = 1'b0;
    run_clear("restart");
    inuse_empty = 1'b1;
  endtask

  task automatic test_settle_init();
    cyc();
    inuse_empty = 1'b0;
    flush_req   = 1'b1;
    cyc();
    flush_req   = 1'b0;
    inuse_empty = 1'b1;
    cyc();
    init_req = 1'b1;
    #1;
    total_cnt++;
    if ({rename_stall, restore_valid, init_clear} !== 3'b100)
      $display("FAIL settle_state got stall=%0b rv=%0b clr=%0b exp 1 0 0", rename_stall, restore_valid, init_clear);
    else pass_cnt++;
    cyc();
    init_req = 1'b0;
    run_clear("settle");
  endtask

`ifdef RENAMER_RECOVERY_WATCHDOG_EN
  task automatic test_watchdog();
    cyc();
    inuse_empty = 1'b0;
    flush_req   = 1'b1;
    cyc();
    flush_req = 1'b0;
    for (int i = 0; i < 33; i++) begin
      #1;
      total_cnt++;
      if ({restore_valid, watchdog_err, init_clear} !== 3'b100)
        $display("FAIL wd_pop%0d got rv=%0b wd=%0b clr=%0b exp 1 0 0", i, restore_valid, watchdog_err, init_clear);
      else pass_cnt++;
      cyc();
    end
    #1;
    total_cnt++;
    if ({watchdog_err, init_clear, clear_index, recover_cycles} !== {2'b11, 6'd0, 6'd33})
      $display("FAIL wd_trip got wd=%0b clr=%0b idx=%0d rc=%0d exp 1 1 0 33",
               watchdog_err, init_clear, clear_index, recover_cycles);
    else pass_cnt++;
    inuse_empty = 1'b1;
    for (int i = 0; i < 64; i++) cyc();
    #1;
    total_cnt++;
    if ({watchdog_err, init_done} !== 2'b11)
      $display("FAIL wd_sticky got wd=%0b done=%0b exp 1 1", watchdog_err, init_done);
    else pass_cnt++;
  endtask
`endif

  task automatic test_async_reset();
    cyc();
    inuse_empty = 1'b0;
    flush_req   = 1'b1;
    cyc();
    flush_req = 1'b0;
    #1;
    total_cnt++;
    if ({restore_valid, busy} !== 2'b11) $display("FAIL areset_pre got rv=%0b busy=%0b exp 1 1", restore_valid, busy);
    else pass_cnt++;
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({init_clear, rename_stall, busy, restore_valid, init_done, clear_index, recover_cycles} !==
        {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 6'd0})
      $display("FAIL areset_values got clr=%0b stall=%0b busy=%0b rv=%0b done=%0b idx=%0d rc=%0d exp 1 1 1 0 0 0 0",
               init_clear, rename_stall, busy, restore_valid, init_done, clear_index, recover_cycles);
    else pass_cnt++;
`ifdef RENAMER_RECOVERY_WATCHDOG_EN
    total_cnt++;
    if (watchdog_err !== 1'b0) $display("FAIL areset_watchdog got=%0b exp=0", watchdog_err);
    else pass_cnt++;
`endif
    cyc();
    rst         = 1'b1;
    inuse_empty = 1'b1;
    run_clear("areset");
  endtask

  initial begin
    test_reset();
    test_init_sequence();
    test_flush_drain();
    test_flush_empty();
    test_back_to_back();
    test_init_abort();
    test_init_conflict();
    test_settle_init();
`ifdef RENAMER_RECOVERY_WATCHDOG_EN
    test_watchdog();
`endif
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
